// File: rtl/msx_wait_pkg.sv
// msx_wait_pkg: shared FSM state type and VDP port decode constants for msx_wait_gen
package msx_wait_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [7:0] VDP_PORT_BASE = 8'h98;
  localparam logic [5:0] VDP_PORT_MASK = 6'b100110;
endpackage

// File: rtl/msx_wait_gen.sv
// msx_wait_gen: Z80 wait-state generator for M1 fetches and, with VDP_IO_WAIT_EN, VDP port I/O
module msx_wait_gen
  import msx_wait_pkg::*;
#(
  parameter int M1_WAITS = 1,
  parameter int IO_WAITS = 2,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en_3m58_p,
  input  logic       clk_en_3m58_n,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  output logic       wait_n,
  output logic       busy
);
  localparam logic [CNT_W-1:0] M1_INIT = CNT_W'(M1_WAITS > 0 ? M1_WAITS - 1 : 0);
  localparam logic [CNT_W-1:0] IO_INIT = CNT_W'(IO_WAITS > 0 ? IO_WAITS - 1 : 0);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic m1_q, iorq_q, m1_start, io_start, n_only;
  assign m1_start = clk_en_3m58_p && !m1_n && m1_q && !mreq_n;
`ifdef VDP_IO_WAIT_EN
  assign io_start = clk_en_3m58_p && !iorq_n && iorq_q && m1_n &&
                    addr[7:2] == VDP_PORT_MASK && (!rd_n || !wr_n);
`else
  logic unused_io;
  assign unused_io = ^{addr, rd_n, wr_n, IO_INIT};
  assign io_start  = 1'b0;
`endif
  // a coincident p-enable takes priority, so n is only honoured alone
  assign n_only = clk_en_3m58_n && !clk_en_3m58_p;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      m1_q   <= 1'b1;
      iorq_q <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (clk_en_3m58_p) begin
        m1_q   <= m1_n;
        iorq_q <= iorq_n;
      end
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (m1_start) begin
          if (M1_WAITS > 0) begin
            state_nx = WAIT;
            cnt_nx   = M1_INIT;
          end
        end else if (io_start && IO_WAITS > 0) begin
          state_nx = WAIT;
          cnt_nx   = IO_INIT;
        end
      end
      WAIT: if (n_only) begin
        if (cnt == '0) state_nx = HOLD;
        else cnt_nx = cnt - 1'b1;
      end
      HOLD: if (clk_en_3m58_p && m1_n && iorq_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    wait_n = state != WAIT;
    busy   = state != IDLE;
  end
endmodule

// File: tb/tb_msx_wait_gen.sv
// tb_msx_wait_gen: random and directed bus cycles on three parameterisations vs a per-cycle wait-count model
module tb_msx_wait_gen;
  logic clk = 1'b0, reset = 1'b1, p = 1'b0, n = 1'b0;
  logic m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [2:0] wn, bz, w_ph0, w_ph1, any_low, any_busy;
  int low_cnt[3];
  int m1w[3] = '{0, 1, 3};
  int iow[3] = '{2, 2, 1};
  int checks = 0, errors = 0;
`ifdef VDP_IO_WAIT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  msx_wait_gen #(.M1_WAITS(0), .IO_WAITS(2)) u0 (
    .clk(clk), .reset(reset), .clk_en_3m58_p(p), .clk_en_3m58_n(n), .m1_n(m1_n), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .addr(addr), .wait_n(wn[0]), .busy(bz[0]));
  msx_wait_gen #(.M1_WAITS(1), .IO_WAITS(2)) u1 (
    .clk(clk), .reset(reset), .clk_en_3m58_p(p), .clk_en_3m58_n(n), .m1_n(m1_n), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .addr(addr), .wait_n(wn[1]), .busy(bz[1]));
  msx_wait_gen #(.M1_WAITS(3), .IO_WAITS(1)) u3 (
    .clk(clk), .reset(reset), .clk_en_3m58_p(p), .clk_en_3m58_n(n), .m1_n(m1_n), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .addr(addr), .wait_n(wn[2]), .busy(bz[2]));

  // Expected stretch in T-states for one bus cycle, straight from the cycle type
  function automatic int exp_waits(int d, int kind, logic [7:0] port);
    if (kind == 0) return m1w[d];
    if ((kind == 2 || kind == 3) && IO_EN && port >= 8'h98 && port <= 8'h9B) return iow[d];
    return 0;
  endfunction

  // One T-state: p-enable on phase 0, n-enable on phase 2, outputs sampled on negedges
  task automatic tstate();
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk);
      if (ph == 0) w_ph0 = wn;
      if (ph == 1) w_ph1 = wn;
      if (ph == 2) for (int d = 0; d < 3; d++) if (!wn[d]) low_cnt[d]++;
      any_low  = any_low | ~wn;
      any_busy = any_busy | bz;
      p = (ph == 0);
      n = (ph == 2);
    end
  endtask

  task automatic bus_idle();
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1;
  endtask

  // kind: 0 M1 fetch, 1 int ack, 2 IO read, 3 IO write, 4 memory read
  task automatic bus_set(int kind, logic [7:0] port);
    bus_idle();
    addr = port;
    case (kind)
      0: begin m1_n = 0; mreq_n = 0; rd_n = 0; end
      1: begin m1_n = 0; iorq_n = 0; end
      2: begin iorq_n = 0; rd_n = 0; end
      3: begin iorq_n = 0; wr_n = 0; end
      default: begin mreq_n = 0; rd_n = 0; end
    endcase
  endtask

  task automatic run_cycle(int kind, logic [7:0] port, int len);
    low_cnt = '{0, 0, 0};
    any_low = '0;
    any_busy = '0;
    bus_set(kind, port);
    repeat (len) tstate();
    bus_idle();
    repeat (4) tstate();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (wn !== 3'b111) begin errors++; $display("FAIL reset_wait_n: got %b expected 111", wn); end
    checks++;
    if (bz !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", bz); end
    reset = 0;
    repeat (2) tstate();
  endtask

  task automatic test_m1_fetch();
    low_cnt = '{0, 0, 0};
    bus_set(0, 8'h00);
    tstate();
    checks++;
    if (w_ph0[1] !== 1'b1) begin errors++; $display("FAIL m1_pre_edge: got %b expected 1", w_ph0[1]); end
    checks++;
    if (w_ph1[1] !== 1'b0) begin errors++; $display("FAIL m1_fall_latency: got %b expected 0", w_ph1[1]); end
    tstate();
    tstate();
    checks++;
    if (bz[1] !== 1'b1) begin errors++; $display("FAIL m1_hold_busy: got %b expected 1", bz[1]); end
    bus_idle();
    tstate();
    checks++;
    if (bz[1] !== 1'b0) begin errors++; $display("FAIL m1_busy_release: got %b expected 0", bz[1]); end
    repeat (3) tstate();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (low_cnt[d] != m1w[d]) begin
        errors++; $display("FAIL m1_count dut%0d: got %0d expected %0d", d, low_cnt[d], m1w[d]);
      end
    end
  endtask

  task automatic test_m1_zero();
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 8'($urandom), 1 + i);
      checks++;
      if (any_low[0] || any_busy[0]) begin
        errors++; $display("FAIL m1_zero cycle%0d: low %b busy %b expected 0 0", i, any_low[0], any_busy[0]);
      end
    end
  endtask

  task automatic test_int_ack();
    run_cycle(1, 8'h98, 3);
    checks++;
    if (any_low !== 3'b000) begin errors++; $display("FAIL int_ack: wait_n low seen %b expected 000", any_low); end
  endtask

  task automatic test_vdp_io();
    run_cycle(3, 8'h98, 4);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (low_cnt[d] != exp_waits(d, 3, 8'h98)) begin
        errors++; $display("FAIL vdp_out dut%0d: got %0d expected %0d", d, low_cnt[d], exp_waits(d, 3, 8'h98));
      end
    end
    run_cycle(2, 8'h99, 4);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (low_cnt[d] != exp_waits(d, 2, 8'h99)) begin
        errors++; $display("FAIL vdp_in dut%0d: got %0d expected %0d", d, low_cnt[d], exp_waits(d, 2, 8'h99));
      end
    end
  endtask

  task automatic test_non_vdp();
    run_cycle(2, 8'hA8, 4);
    checks++;
    if (any_low !== 3'b000) begin errors++; $display("FAIL ppi_in: wait_n low seen %b expected 000", any_low); end
    run_cycle(3, 8'h9C, 4);
    checks++;
    if (any_low !== 3'b000) begin errors++; $display("FAIL port_9c: wait_n low seen %b expected 000", any_low); end
  endtask

  task automatic test_reset_mid_wait();
    low_cnt = '{0, 0, 0};
    bus_set(0, 8'h00);
    tstate();
    checks++;
    if (low_cnt[2] != 1) begin errors++; $display("FAIL mid_first_n: got %0d expected 1", low_cnt[2]); end
    #2 reset = 1;
    #1;
    checks++;
    if (wn[2] !== 1'b1 || bz[2] !== 1'b0) begin
      errors++; $display("FAIL async_reset: wait_n %b busy %b expected 1 0", wn[2], bz[2]);
    end
    bus_idle();
    @(negedge clk) reset = 0;
    repeat (2) tstate();
    run_cycle(0, 8'h00, 2);
    checks++;
    if (low_cnt[2] != 3) begin errors++; $display("FAIL post_reset_m1: got %0d expected 3", low_cnt[2]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 4);
      logic [7:0] port = $urandom_range(0, 1) ? {6'b100110, 2'($urandom)} : 8'($urandom);
      run_cycle(kind, port, $urandom_range(1, 5));
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (low_cnt[d] != exp_waits(d, kind, port)) begin
          errors++;
          $display("FAIL rand%0d dut%0d kind%0d port %h: got %0d expected %0d",
                   i, d, kind, port, low_cnt[d], exp_waits(d, kind, port));
        end
      end
      checks++;
      if (bz !== 3'b000) begin errors++; $display("FAIL rand%0d idle_busy: got %b expected 000", i, bz); end
    end
  endtask

  initial begin
    test_reset();
    test_m1_fetch();
    test_m1_zero();
    test_int_ack();
    test_vdp_io();
    test_non_vdp();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
